// File: rtl/led_activity_stretcher.sv
// Stretches short LED activity pulses to a visible hold of HOLD_MS ms ticks.
// Latency: 2 cycles rise, 3 with LED_PWM_DIM_EN (dims led_out with a 1/16-step PWM).
// Backpressure: none; every channel is sampled every cycle.
module led_activity_stretcher #(
  parameter int CH_NUM      = 16,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int HOLD_MS     = 50,
  parameter int PWM_DUTY    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_NUM-1:0] led_in,
  output logic [CH_NUM-1:0] led_out,
  output logic              ms_tick,
  output logic              any_active
);

  localparam int P  = CLK_FREQ_HZ / 1000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = $clog2(HOLD_MS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(P - 1);
  localparam logic [CW-1:0] HOLD_VAL   = CW'(HOLD_MS);

  logic [PW-1:0]     presc;
  logic [CH_NUM-1:0] in_reg;
  logic [CW-1:0]     cnt [CH_NUM];
  logic [CH_NUM-1:0] stretched;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign ms_tick = (presc == PRESC_LAST);

  // Same clock domain as the MPSoC, so a single capture register is enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg <= '0;
    end else begin
      in_reg <= led_in;
    end
  end

  // A fresh input reloads the hold, even on a tick cycle; the count saturates at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (in_reg[i]) begin
          cnt[i] <= HOLD_VAL;
        end else if (ms_tick && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stretched <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        stretched[i] <= in_reg[i] | (cnt[i] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_active <= 1'b0;
    end else begin
      any_active <= |stretched;
    end
  end

`ifdef LED_PWM_DIM_EN
  localparam logic [4:0] DUTY_VAL = 5'(PWM_DUTY);

  logic [3:0] pwm_cnt;
  logic       pwm_on;

  // Compared at 5 bits so PWM_DUTY=16 means always on.
  assign pwm_on = ({1'b0, pwm_cnt} < DUTY_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      led_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_out <= stretched & {CH_NUM{pwm_on}};
    end
  end
`else
  assign led_out = stretched;
`endif

endmodule
